// File: rtl/bus_cfg_pkg.sv
// Shared field encodings, widths and helpers for the button/config front end.
package bus_cfg_pkg;

  localparam int SW_W       = 12;
  localparam int NUM_FIELDS = 7;
  localparam int FLD_W      = 3;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;
  localparam int BLEN_W     = 4;
  localparam int SLAVE_W    = 2;
  localparam int NUM_SLAVES = 3;

  localparam logic [SLAVE_W-1:0] SLAVE_LAST = SLAVE_W'(NUM_SLAVES - 1);

  typedef enum logic [FLD_W-1:0] {
    FLD_ADDR      = 3'd0,
    FLD_MASTER    = 3'd1,
    FLD_SLAVE     = 3'd2,
    FLD_DATA      = 3'd3,
    FLD_BURST_LEN = 3'd4,
    FLD_BURST_EN  = 3'd5,
    FLD_COMMIT    = 3'd6
  } field_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic               master;
    logic [SLAVE_W-1:0] slave;
    logic [DATA_W-1:0]  data;
    logic [BLEN_W-1:0]  burst_len;
    logic               burst_en;
  } cfg_t;

  function automatic field_e next_field(input field_e f);
    return (int'(f) == NUM_FIELDS - 1) ? FLD_ADDR : field_e'(f + 3'd1);
  endfunction

  function automatic logic [SLAVE_W-1:0] next_slave(input logic [SLAVE_W-1:0] s);
    return (s == SLAVE_LAST) ? '0 : s + SLAVE_W'(1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises one raw active-low button, accepts a level after DEBOUNCE_CYCLES
// equal samples, and emits a single-cycle pulse on each accepted press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q, stable_q, pulse_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Released buttons read high, so the whole chain resets to 1 to avoid a fake press.
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
        pulse_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_o = pulse_q;

endmodule

// File: rtl/button_config_frontend.sv
// Button conditioning plus the 7-field configuration sequencer and run-mode
// master start generator feeding the bus core.
module button_config_frontend
  import bus_cfg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               enable,
  input  logic               button1_raw,
  input  logic               button2_raw,
  input  logic               button3_raw,
  input  logic               mode_switch,
  input  logic               rw_switch1,
  input  logic               rw_switch2,
  input  logic [SW_W-1:0]    switch_array,
  output logic [FLD_W-1:0]   field_idx,
  output logic [ADDR_W-1:0]  cfg_addr,
  output logic               cfg_master,
  output logic [SLAVE_W-1:0] cfg_slave,
  output logic [DATA_W-1:0]  cfg_data,
  output logic [BLEN_W-1:0]  cfg_burst_len,
  output logic               cfg_burst_en,
  output logic               m1_start,
  output logic               m2_start,
  output logic               m1_rw,
  output logic               m2_rw
);

  logic b1_p, b2_p, b3_p;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clk_i(clock), .rst_i(rst), .btn_n_i(button1_raw), .press_o(b1_p));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
    .clk_i(clock), .rst_i(rst), .btn_n_i(button2_raw), .press_o(b2_p));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db3 (
    .clk_i(clock), .rst_i(rst), .btn_n_i(button3_raw), .press_o(b3_p));

  field_e field_q, field_d;
  cfg_t   cfg_q, cfg_d;
  logic   m1_start_q, m1_start_d, m2_start_q, m2_start_d;
  logic   m1_rw_q, m1_rw_d, m2_rw_q, m2_rw_d;

  always_ff @(posedge clock) begin
    if (rst) begin
      field_q    <= FLD_ADDR;
      cfg_q      <= '0;
      m1_start_q <= 1'b0;
      m2_start_q <= 1'b0;
      m1_rw_q    <= 1'b0;
      m2_rw_q    <= 1'b0;
    end else begin
      field_q    <= field_d;
      cfg_q      <= cfg_d;
      m1_start_q <= m1_start_d;
      m2_start_q <= m2_start_d;
      m1_rw_q    <= m1_rw_d;
      m2_rw_q    <= m2_rw_d;
    end
  end

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    field_d    = field_q;
    cfg_d      = cfg_q;
    m1_start_d = 1'b0;
    m2_start_d = 1'b0;
    m1_rw_d    = m1_rw_q;
    m2_rw_d    = m2_rw_q;

    if (enable) begin
      if (mode_switch) begin
        if (b1_p) begin
          m1_start_d = 1'b1;
          m1_rw_d    = rw_switch1;
        end
        if (b2_p) begin
          m2_start_d = 1'b1;
          m2_rw_d    = rw_switch2;
        end
      end else begin
        // Select edits MASTER/SLAVE only, so it never collides with the capture below.
        if (b1_p) begin
          case (field_q)
            FLD_MASTER: cfg_d.master = ~cfg_q.master;
            FLD_SLAVE:  cfg_d.slave  = next_slave(cfg_q.slave);
            default: ;
          endcase
        end
        if (b3_p) begin
          case (field_q)
            FLD_ADDR:      cfg_d.addr      = switch_array[ADDR_W-1:0];
            FLD_DATA:      cfg_d.data      = switch_array[DATA_W-1:0];
            FLD_BURST_LEN: cfg_d.burst_len = switch_array[BLEN_W-1:0];
            FLD_BURST_EN:  cfg_d.burst_en  = switch_array[0];
            default: ;
          endcase
          field_d = next_field(field_q);
        end
      end
    end
  end

  assign field_idx     = field_q;
  assign cfg_addr      = cfg_q.addr;
  assign cfg_master    = cfg_q.master;
  assign cfg_slave     = cfg_q.slave;
  assign cfg_data      = cfg_q.data;
  assign cfg_burst_len = cfg_q.burst_len;
  assign cfg_burst_en  = cfg_q.burst_en;
  assign m1_start      = m1_start_q;
  assign m2_start      = m2_start_q;
  assign m1_rw         = m1_rw_q;
  assign m2_rw         = m2_rw_q;

endmodule

// File: tb/tb_button_config_frontend.sv
// Directed bench: a small config model pushes expected snapshots/start events
// into queues, which are popped and compared once the DUT has responded.
module tb_button_config_frontend;
  import bus_cfg_pkg::*;

  localparam int D = 10;

  logic        clock = 1'b0;
  logic        rst, enable, b1, b2, b3, mode, rw1, rw2;
  logic [11:0] sw;
  logic [2:0]  field_idx;
  logic [11:0] cfg_addr;
  logic        cfg_master;
  logic [1:0]  cfg_slave;
  logic [7:0]  cfg_data;
  logic [3:0]  cfg_burst_len;
  logic        cfg_burst_en, m1_start, m2_start, m1_rw, m2_rw;

  always #5 clock = ~clock;

  button_config_frontend #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .rst(rst), .enable(enable),
    .button1_raw(b1), .button2_raw(b2), .button3_raw(b3),
    .mode_switch(mode), .rw_switch1(rw1), .rw_switch2(rw2), .switch_array(sw),
    .field_idx(field_idx), .cfg_addr(cfg_addr), .cfg_master(cfg_master),
    .cfg_slave(cfg_slave), .cfg_data(cfg_data), .cfg_burst_len(cfg_burst_len),
    .cfg_burst_en(cfg_burst_en), .m1_start(m1_start), .m2_start(m2_start),
    .m1_rw(m1_rw), .m2_rw(m2_rw));

  typedef struct packed {
    logic [2:0]  fld;
    logic [11:0] addr;
    logic        master;
    logic [1:0]  slave;
    logic [7:0]  data;
    logic [3:0]  blen;
    logic        ben;
  } snap_t;

  snap_t      exp_cfg_q[$];
  logic [3:0] exp_start_q[$];
  logic [3:0] obs_start_q[$];
  snap_t      m;
  logic       m1_rw_m, m2_rw_m;
  int         errors = 0;
  int         checks = 0;

  // Start events as {m1_start, m1_rw, m2_start, m2_rw}.
  always @(negedge clock)
    if (m1_start || m2_start) obs_start_q.push_back({m1_start, m1_rw, m2_start, m2_rw});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [2:0] which, input int hold);
    if (which[0]) b1 = 1'b0;
    if (which[1]) b2 = 1'b0;
    if (which[2]) b3 = 1'b0;
    tick(hold);
    b1 = 1'b1; b2 = 1'b1; b3 = 1'b1;
    tick(D + 6);
  endtask

  task automatic model_next();
    case (m.fld)
      3'd0: m.addr = sw;
      3'd3: m.data = sw[7:0];
      3'd4: m.blen = sw[3:0];
      3'd5: m.ben  = sw[0];
      default: ;
    endcase
    m.fld = (m.fld == 3'd6) ? 3'd0 : m.fld + 3'd1;
  endtask

  task automatic model_select();
    if (m.fld == 3'd1) m.master = ~m.master;
    if (m.fld == 3'd2) m.slave = (m.slave == 2'd2) ? 2'd0 : m.slave + 2'd1;
  endtask

  task automatic expect_cfg();
    exp_cfg_q.push_back(m);
  endtask

  task automatic compare_cfg(input string tag);
    snap_t e;
    e = exp_cfg_q.pop_front();
    check({tag, ".field"},  32'(field_idx),     32'(e.fld));
    check({tag, ".addr"},   32'(cfg_addr),      32'(e.addr));
    check({tag, ".master"}, 32'(cfg_master),    32'(e.master));
    check({tag, ".slave"},  32'(cfg_slave),     32'(e.slave));
    check({tag, ".data"},   32'(cfg_data),      32'(e.data));
    check({tag, ".blen"},   32'(cfg_burst_len), 32'(e.blen));
    check({tag, ".ben"},    32'(cfg_burst_en),  32'(e.ben));
  endtask

  task automatic compare_starts(input string tag);
    check({tag, ".count"}, 32'(obs_start_q.size()), 32'(exp_start_q.size()));
    while (obs_start_q.size() > 0 && exp_start_q.size() > 0)
      check({tag, ".event"}, 32'(obs_start_q.pop_front()), 32'(exp_start_q.pop_front()));
    obs_start_q.delete();
    exp_start_q.delete();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; b1 = 1'b1; b2 = 1'b1; b3 = 1'b1;
    mode = 1'b0; rw1 = 1'b0; rw2 = 1'b0; sw = '0;
    m = '0; m1_rw_m = 1'b0; m2_rw_m = 1'b0;
    tick(3);
    rst = 1'b0;

    // Reset state and 100 idle cycles
    expect_cfg();
    compare_cfg("reset");
    check("reset.m1_start", 32'(m1_start), 32'd0);
    check("reset.m2_start", 32'(m2_start), 32'd0);
    check("reset.m1_rw",    32'(m1_rw),    32'd0);
    check("reset.m2_rw",    32'(m2_rw),    32'd0);
    tick(100);
    expect_cfg();
    compare_cfg("idle");
    compare_starts("idle");

    // Bounce on button3, then a clean hold: one pulse 12 cycles after the last low edge
    for (int i = 0; i < 10; i++) begin
      b3 = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
    end
    b3 = 1'b0;
    tick(D + 2);
    check("bounce.before_pulse", 32'(field_idx), 32'd0);
    tick(1);
    check("bounce.after_pulse", 32'(field_idx), 32'd1);
    model_next();
    tick(40);
    b3 = 1'b1;
    tick(D + 6);
    expect_cfg();
    compare_cfg("bounce_hold");

    rst = 1'b1; tick(2); rst = 1'b0; m = '0; tick(1);

    // Seven next presses with sw=18 walk every field and wrap to 0
    sw = 12'd18;
    for (int i = 0; i < 7; i++) begin
      press(3'b100, D + 4);
      model_next();
      expect_cfg();
      compare_cfg("cfg_next");
    end
    check("cfg.addr18",  32'(cfg_addr),      32'd18);
    check("cfg.data18",  32'(cfg_data),      32'd18);
    check("cfg.blen2",   32'(cfg_burst_len), 32'd2);
    check("cfg.ben0",    32'(cfg_burst_en),  32'd0);
    check("cfg.wrap0",   32'(field_idx),     32'd0);

    // Select on MASTER and SLAVE fields
    press(3'b100, D + 4); model_next();
    press(3'b001, D + 4); model_select();
    expect_cfg(); compare_cfg("sel_master");
    check("sel.master1", 32'(cfg_master), 32'd1);
    press(3'b100, D + 4); model_next();
    for (int i = 0; i < 3; i++) begin
      logic [1:0] slave_tbl [3];
      slave_tbl = '{2'd1, 2'd2, 2'd0};
      press(3'b001, D + 4); model_select();
      expect_cfg(); compare_cfg("sel_slave");
      check("sel.slave_seq", 32'(cfg_slave), 32'(slave_tbl[i]));
    end
    // Select and next together on SLAVE: select applies, then advance
    press(3'b101, D + 4); model_select(); model_next();
    expect_cfg(); compare_cfg("sel_next_same");

    // Disabled: presses are dropped
    enable = 1'b0;
    press(3'b100, D + 4);
    press(3'b001, D + 4);
    enable = 1'b1;
    tick(2);
    expect_cfg(); compare_cfg("cfg_disabled");

    // Run mode: long hold gives exactly one start; cfg frozen
    mode = 1'b1; rw1 = 1'b1; rw2 = 1'b0;
    m2_rw_m = 1'b0;
    exp_start_q.push_back({1'b0, m1_rw_m, 1'b1, m2_rw_m});
    press(3'b010, 200);
    compare_starts("run_b2_hold");
    check("run.m2_rw", 32'(m2_rw), 32'd0);
    press(3'b100, D + 4);
    m1_rw_m = 1'b1;
    exp_start_q.push_back({1'b1, m1_rw_m, 1'b0, m2_rw_m});
    press(3'b001, D + 4);
    rw1 = 1'b0; rw2 = 1'b1;
    m1_rw_m = 1'b0; m2_rw_m = 1'b1;
    exp_start_q.push_back({1'b1, m1_rw_m, 1'b1, m2_rw_m});
    press(3'b011, D + 4);
    compare_starts("run_b1_both");
    enable = 1'b0;
    press(3'b011, D + 4);
    enable = 1'b1;
    compare_starts("run_disabled");
    expect_cfg(); compare_cfg("run_frozen");

    // Back to config, reach BURST_LEN, then reset during a bounce
    mode = 1'b0;
    press(3'b100, D + 4); model_next();
    expect_cfg(); compare_cfg("pre_rst");
    check("pre_rst.field4", 32'(field_idx), 32'd4);
    for (int i = 0; i < 4; i++) begin
      b3 = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
    end
    b3 = 1'b0;
    tick(8);
    rst = 1'b1; b3 = 1'b1;
    tick(2);
    rst = 1'b0;
    m = '0; m1_rw_m = 1'b0; m2_rw_m = 1'b0;
    tick(30);
    expect_cfg(); compare_cfg("rst_mid");
    compare_starts("rst_mid");
    check("rst_mid.m2_rw", 32'(m2_rw), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
